shifter_seq: RTL and testbench

SHIFTER_SEQ -- requirements
Module: shifter_seq

---
 rtl/shifter_pkg.sv | 28 ++
 rtl/shift_step.sv | 12 +
 rtl/shifter_seq.sv | 119 +++++++++++
 tb/tb_shifter_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared constants for the sequential shifter: operation and FSM state encodings.
package shifter_pkg;

    // Operation encoding: bit 1 selects variable amount, bit 0 selects left shift.
    typedef enum logic [1:0] {
        OP_SRL1 = 2'b00,
        OP_SLL1 = 2'b01,
        OP_SRLV = 2'b10,
        OP_SLLV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // True when the operation shifts towards the MSB.
    function automatic logic op_is_left(input op_e op);
        return op[0];
    endfunction

    // True when the shift count comes from amt_i instead of being fixed at one.
    function automatic logic op_is_var(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit logical shift step, zero fill in both directions. Requires WIDTH >= 2.
module shift_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  logic             left,
    output logic [WIDTH-1:0] result
);

    assign result = left ? {data[WIDTH-2:0], 1'b0} : {1'b0, data[WIDTH-1:1]};

endmodule

// File: rtl/shifter_seq.sv
// Sequential shifter: captures an operand and shift count, then shifts one bit
// per clock until the count is exhausted, and holds the result until the
// consumer takes it. AMT_W up to 32 is supported.
module shifter_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_i,
    input  logic [AMT_W-1:0] amt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   count_q;
    logic               left_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    op_e                op;
    logic [CNT_W-1:0]   n_eff;
    logic [WIDTH-1:0]   step_data;

    assign op = op_e'(op_i);

    // Effective shift count: one for fixed ops, amt_i saturated at WIDTH otherwise.
    always_comb begin
        // NOTE: n_eff gets a default before any branch so every path assigns it and no latch is inferred.
        n_eff = CNT_W'(1);
        if (op_is_var(op)) begin
            if (32'(amt_i) >= 32'(WIDTH)) begin
                n_eff = CNT_W'(WIDTH);
            end else begin
                n_eff = CNT_W'(amt_i);
            end
        end
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .data   (data_q),
        .left   (left_q),
        .result (step_data)
    );

    // Control FSM with registered handshake outputs; data and count live alongside.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            count_q     <= '0;
            left_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        data_q     <= src_i;
                        left_q     <= op_is_left(op);
                        count_q    <= n_eff;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (n_eff == '0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q  <= step_data;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign result_o    = data_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Directed bench for shifter_seq: reset, each op, saturation, backpressure,
// back-to-back requests and asynchronous reset mid-operation.
module tb_shifter_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [15:0] src_i = '0;
    logic [15:0] amt_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] result_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    shifter_seq #(
        .WIDTH (16),
        .AMT_W (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .src_i       (src_i),
        .amt_i       (amt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for exactly one accept edge, then drop in_valid_i.
    task automatic accept(input logic [1:0] op, input logic [15:0] src, input logic [15:0] amt);
        in_valid_i = 1'b1;
        op_i       = op;
        src_i      = src;
        amt_i      = amt;
        tick();
        in_valid_i = 1'b0;
        op_i       = 2'b00;
        src_i      = 16'hDEAD;
        amt_i      = 16'h0;
    endtask

    // Count edges until out_valid_o rises, bounded by max.
    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (out_valid_o !== 1'b1 && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        tick();
        tick();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy_o); end
        checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL reset result: got %h want 0000", result_o); end
        rst_i = 1'b1;
        tick();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b want 1", in_ready_o); end
    endtask

    task automatic test_srl_var();
        int cyc;
        out_ready_i = 1'b1;
        accept(2'b10, 16'hF000, 16'd4);
        checks++; if (busy_o !== 1'b1 || in_ready_o !== 1'b0) begin errors++; $display("FAIL srlv busy/ready: got %b/%b want 1/0", busy_o, in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL srlv early valid: got %b want 0", out_valid_o); end
        tick();
        checks++; if (result_o !== 16'h7800) begin errors++; $display("FAIL srlv first step: got %h want 7800", result_o); end
        wait_valid(40, cyc);
        checks++; if (cyc + 1 !== 4) begin errors++; $display("FAIL srlv latency: got %0d want 4", cyc + 1); end
        checks++; if (result_o !== 16'h0F00) begin errors++; $display("FAIL srlv result: got %h want 0F00", result_o); end
        tick();
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL srlv return idle: ready/valid/busy got %b/%b/%b want 1/0/0", in_ready_o, out_valid_o, busy_o);
        end
    endtask

    task automatic test_sll1();
        int cyc;
        out_ready_i = 1'b1;
        accept(2'b01, 16'h8001, 16'd9);
        wait_valid(40, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL sll1 latency: got %0d want 1", cyc); end
        checks++; if (result_o !== 16'h0002) begin errors++; $display("FAIL sll1 result: got %h want 0002", result_o); end
        tick();
    endtask

    task automatic test_srl1();
        int cyc;
        out_ready_i = 1'b1;
        accept(2'b00, 16'h0003, 16'd7);
        wait_valid(40, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL srl1 latency: got %0d want 1", cyc); end
        checks++; if (result_o !== 16'h0001) begin errors++; $display("FAIL srl1 result: got %h want 0001", result_o); end
        tick();
    endtask

    task automatic test_zero_amt();
        out_ready_i = 1'b1;
        accept(2'b11, 16'h1234, 16'd0);
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL zero-amt valid after accept: got %b want 1", out_valid_o); end
        checks++; if (result_o !== 16'h1234) begin errors++; $display("FAIL zero-amt result: got %h want 1234", result_o); end
        tick();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL zero-amt return idle: got %b want 1", in_ready_o); end
    endtask

    task automatic test_saturate();
        int cyc;
        out_ready_i = 1'b1;
        accept(2'b10, 16'hFFFF, 16'd20);
        wait_valid(60, cyc);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL sat srl latency: got %0d want 16", cyc); end
        checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL sat srl result: got %h want 0000", result_o); end
        tick();
        accept(2'b11, 16'hFFFF, 16'd16);
        wait_valid(60, cyc);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL sat sll latency: got %0d want 16", cyc); end
        checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL sat sll result: got %h want 0000", result_o); end
        tick();
        accept(2'b11, 16'h0001, 16'd15);
        wait_valid(60, cyc);
        checks++; if (cyc !== 15) begin errors++; $display("FAIL sll15 latency: got %0d want 15", cyc); end
        checks++; if (result_o !== 16'h8000) begin errors++; $display("FAIL sll15 result: got %h want 8000", result_o); end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready_i = 1'b0;
        accept(2'b11, 16'h00F0, 16'd3);
        wait_valid(40, cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL bp latency: got %0d want 3", cyc); end
        in_valid_i = 1'b1;
        op_i       = 2'b00;
        src_i      = 16'hAAAA;
        amt_i      = 16'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid_o !== 1'b1 || result_o !== 16'h0780 || in_ready_o !== 1'b0) begin
                errors++; $display("FAIL bp hold %0d: valid/result/ready got %b/%h/%b want 1/0780/0", i, out_valid_o, result_o, in_ready_o);
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL bp handoff: ready/valid got %b/%b want 1/0", in_ready_o, out_valid_o);
        end
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bp ignored request: busy got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready_i = 1'b0;
        accept(2'b00, 16'h8000, 16'd5);
        wait_valid(40, cyc);
        checks++; if (result_o !== 16'h4000 || cyc !== 1) begin
            errors++; $display("FAIL b2b first: result/latency got %h/%0d want 4000/1", result_o, cyc);
        end
        in_valid_i = 1'b1;
        op_i       = 2'b01;
        src_i      = 16'h0001;
        amt_i      = 16'd3;
        tick();
        checks++; if (out_valid_o !== 1'b1 || result_o !== 16'h4000) begin
            errors++; $display("FAIL b2b held: valid/result got %b/%h want 1/4000", out_valid_o, result_o);
        end
        out_ready_i = 1'b1;
        tick();
        checks++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b no accept at handoff: ready/busy/valid got %b/%b/%b want 1/0/0", in_ready_o, busy_o, out_valid_o);
        end
        tick();
        checks++; if (busy_o !== 1'b1 || in_ready_o !== 1'b0) begin
            errors++; $display("FAIL b2b second accept: busy/ready got %b/%b want 1/0", busy_o, in_ready_o);
        end
        in_valid_i = 1'b0;
        tick();
        checks++; if (out_valid_o !== 1'b1 || result_o !== 16'h0002) begin
            errors++; $display("FAIL b2b second result: valid/result got %b/%h want 1/0002", out_valid_o, result_o);
        end
        tick();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b final idle: got %b want 1", in_ready_o); end
    endtask

    task automatic test_reset_mid_op();
        out_ready_i = 1'b1;
        accept(2'b10, 16'hFFFF, 16'd10);
        tick();
        tick();
        tick();
        checks++; if (result_o !== 16'h1FFF || busy_o !== 1'b1) begin
            errors++; $display("FAIL mid-shift data: result/busy got %h/%b want 1FFF/1", result_o, busy_o);
        end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 16'h0000 || busy_o !== 1'b0) begin
            errors++; $display("FAIL async reset shift: ready/valid/result/busy got %b/%b/%h/%b want 1/0/0000/0", in_ready_o, out_valid_o, result_o, busy_o);
        end
        tick();
        rst_i = 1'b1;
        tick();
        tick();
        checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL shift aborted: valid/busy got %b/%b want 0/0", out_valid_o, busy_o);
        end
        out_ready_i = 1'b0;
        accept(2'b01, 16'h0001, 16'd0);
        tick();
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL pre-reset done: got %b want 1", out_valid_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0 || result_o !== 16'h0000 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL async reset done: valid/result/ready got %b/%h/%b want 0/0000/1", out_valid_o, result_o, in_ready_o);
        end
        tick();
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        tick();
        tick();
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL done discarded: valid/ready got %b/%b want 0/1", out_valid_o, in_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_srl_var();
        test_sll1();
        test_srl1();
        test_zero_amt();
        test_saturate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
